// File: rtl/audio_sample_pacer.sv
// audio_sample_pacer
// Phase-accumulator sample-rate generator feeding an N-channel sample FIFO.
// Each accumulator carry produces a one-cycle o_strobe. On that same edge the
// head word is popped into o_sample. Underrun and overrun are sticky flags.
module audio_sample_pacer #(
   parameter int unsigned ACC_WIDTH     = 32,
   parameter int unsigned CHANNELS      = 2,
   parameter int unsigned SAMPLE_WIDTH  = 24,
   parameter int unsigned FIFO_DEPTH    = 8,
   parameter bit          UNDERRUN_ZERO = 1'b0
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 i_enable,
   input  logic [ACC_WIDTH-1:0]                 i_phase_inc,
   input  logic                                 i_clr_flags,
   input  logic                                 s_valid,
   output logic                                 s_ready,
   input  logic [CHANNELS*SAMPLE_WIDTH-1:0]     s_data,
   output logic                                 o_strobe,
   output logic [CHANNELS*SAMPLE_WIDTH-1:0]     o_sample,
   output logic [$clog2(FIFO_DEPTH):0]          o_level,
   output logic                                 o_underrun,
   output logic                                 o_overrun
);

   localparam int unsigned WORD_W = CHANNELS * SAMPLE_WIDTH;
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W  = PTR_W + 1;

   // accumulator and strobe
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [ACC_WIDTH:0]   sum;
   logic                 carry;
   logic                 strobe_q, strobe_d;

   // fifo storage and bookkeeping
   logic [WORD_W-1:0]    mem_q [FIFO_DEPTH];
   logic [WORD_W-1:0]    mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]     level_q, level_d;
   logic                 ready_q, ready_d;
   logic                 push, pop;

   // output sample and sticky flags
   logic [WORD_W-1:0]    sample_q, sample_d;
   logic                 underrun_q, underrun_d;
   logic                 overrun_q, overrun_d;
   logic                 underrun_set, overrun_set;

   // Phase accumulator: widened add so the carry out is the strobe request
   always_comb begin
      sum      = {1'b0, acc_q} + {1'b0, i_phase_inc};
      carry    = i_enable & sum[ACC_WIDTH];
      acc_d    = i_enable ? sum[ACC_WIDTH-1:0] : acc_q;
      strobe_d = carry;
   end

   // Push/pop decisions. Pop sees only the registered level, so a word
   // written on this edge cannot be popped on the same edge.
   always_comb begin
      push         = s_valid & ready_q;
      pop          = carry & (level_q != '0);
      underrun_set = carry & (level_q == '0);
      overrun_set  = s_valid & ~ready_q;
   end

   // FIFO storage, pointers, level and registered ready
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         mem_d[wr_ptr_q] = s_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
      ready_d = (level_d < LVL_W'(FIFO_DEPTH));
   end

   // Output sample: load head on pop, otherwise hold or zero on underrun
   always_comb begin
      sample_d = sample_q;
      if (pop) begin
         sample_d = mem_q[rd_ptr_q];
      end else if (underrun_set && UNDERRUN_ZERO) begin
         sample_d = '0;
      end
   end

   // Sticky flags: a set event in the same cycle overrides the clear
   always_comb begin
      underrun_d = (underrun_q & ~i_clr_flags) | underrun_set;
      overrun_d  = (overrun_q  & ~i_clr_flags) | overrun_set;
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q      <= '0;
         strobe_q   <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         ready_q    <= 1'b1;
         sample_q   <= '0;
         underrun_q <= 1'b0;
         overrun_q  <= 1'b0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         acc_q      <= acc_d;
         strobe_q   <= strobe_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         ready_q    <= ready_d;
         sample_q   <= sample_d;
         underrun_q <= underrun_d;
         overrun_q  <= overrun_d;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   // Port mapping
   always_comb begin
      s_ready    = ready_q;
      o_strobe   = strobe_q;
      o_sample   = sample_q;
      o_level    = level_q;
      o_underrun = underrun_q;
      o_overrun  = overrun_q;
   end

endmodule

// File: tb/tb_audio_sample_pacer.sv
// Directed bench for audio_sample_pacer. It uses an 8-bit accumulator so that
// strobe timing is short and exact. A queue holds the words the FIFO should
// deliver, and every observed strobe pops the next expected o_sample.
module tb_audio_sample_pacer;

   localparam int unsigned AW = 8;
   localparam int unsigned WW = 48;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           i_enable;
   logic [AW-1:0]  i_phase_inc;
   logic           i_clr_flags;
   logic           s_valid;
   logic           s_ready;
   logic [WW-1:0]  s_data;
   logic           o_strobe;
   logic [WW-1:0]  o_sample;
   logic [3:0]     o_level;
   logic           o_underrun;
   logic           o_overrun;

   int             checks = 0;
   int             errors = 0;
   int             n_strobes = 0;
   int             base;
   logic [WW-1:0]  sbq [$];
   logic [WW-1:0]  last_exp = '0;

   audio_sample_pacer #(
      .ACC_WIDTH     (AW),
      .CHANNELS      (2),
      .SAMPLE_WIDTH  (24),
      .FIFO_DEPTH    (8),
      .UNDERRUN_ZERO (1'b0)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_enable    (i_enable),
      .i_phase_inc (i_phase_inc),
      .i_clr_flags (i_clr_flags),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .o_strobe    (o_strobe),
      .o_sample    (o_sample),
      .o_level     (o_level),
      .o_underrun  (o_underrun),
      .o_overrun   (o_overrun)
   );

   always #5 clk = ~clk;

   function automatic logic [WW-1:0] w(input int n);
      return {24'(n), 24'(n)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock; outputs are examined on the falling edge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      if (o_strobe === 1'b1) begin
         n_strobes++;
         if (sbq.size() > 0) last_exp = sbq.pop_front();
         chk("sample_on_strobe", 64'(o_sample), 64'(last_exp));
      end else begin
         chk("sample_hold", 64'(o_sample), 64'(last_exp));
      end
   endtask

   task automatic push(input logic [WW-1:0] d, input bit accept);
      s_valid = 1'b1;
      s_data  = d;
      if (accept) sbq.push_back(d);
      tick();
      s_valid = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      i_enable    = 1'b0;
      i_phase_inc = AW'(64);
      i_clr_flags = 1'b0;
      s_valid     = 1'b0;
      s_data      = '0;

      // reset state
      @(negedge clk);
      chk("rst_strobe",   64'(o_strobe),   64'(0));
      chk("rst_sample",   64'(o_sample),   64'(0));
      chk("rst_level",    64'(o_level),    64'(0));
      chk("rst_ready",    64'(s_ready),    64'(1));
      chk("rst_underrun", 64'(o_underrun), 64'(0));
      chk("rst_overrun",  64'(o_overrun),  64'(0));
      tick();

      // inc=64 on 8 bits: strobe on every 4th cycle after release
      rst_n    = 1'b1;
      i_enable = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk("t1_strobe", 64'(o_strobe), 64'(k % 4 == 0));
      end
      chk("t1_underrun", 64'(o_underrun), 64'(1));
      i_enable    = 1'b0;
      i_clr_flags = 1'b1;
      tick();
      i_clr_flags = 1'b0;
      chk("t1_clr", 64'(o_underrun), 64'(0));

      // three words, four strobes: 1,2,3 then repeat 3 with underrun
      push(w(1), 1'b1);
      push(w(2), 1'b1);
      push(w(3), 1'b1);
      chk("t3_level", 64'(o_level), 64'(3));
      i_enable = 1'b1;
      base = n_strobes;
      for (int i = 0; i < 40 && (n_strobes - base) < 4; i++) begin
         tick();
         if (o_strobe === 1'b1 && (n_strobes - base) == 3)
            chk("t3_no_underrun_yet", 64'(o_underrun), 64'(0));
      end
      i_enable = 1'b0;
      chk("t3_strobe_count", 64'(n_strobes - base), 64'(4));
      chk("t3_underrun", 64'(o_underrun), 64'(1));
      chk("t3_repeat_last", 64'(o_sample), 64'(w(3)));
      chk("t3_level_empty", 64'(o_level), 64'(0));
      i_clr_flags = 1'b1;
      tick();
      i_clr_flags = 1'b0;
      chk("t3_clr", 64'(o_underrun), 64'(0));

      // fill to depth, then a refused ninth push
      for (int i = 0; i < 8; i++) push(w(16 + i), 1'b1);
      chk("t4_ready_full", 64'(s_ready), 64'(0));
      chk("t4_level_full", 64'(o_level), 64'(8));
      push(w(99), 1'b0);
      chk("t4_overrun", 64'(o_overrun), 64'(1));
      chk("t4_level_kept", 64'(o_level), 64'(8));
      // clear coincident with a new overrun: flag must stay set
      s_valid     = 1'b1;
      s_data      = w(98);
      i_clr_flags = 1'b1;
      tick();
      chk("t4_set_wins", 64'(o_overrun), 64'(1));
      s_valid = 1'b0;
      tick();
      i_clr_flags = 1'b0;
      chk("t4_clr", 64'(o_overrun), 64'(0));

      // full FIFO, strobe with s_valid held: push refused, ready returns
      s_valid  = 1'b1;
      s_data   = w(77);
      i_enable = 1'b1;
      base = n_strobes;
      for (int i = 0; i < 20 && n_strobes == base; i++) tick();
      s_valid  = 1'b0;
      i_enable = 1'b0;
      chk("t5_strobe_count", 64'(n_strobes - base), 64'(1));
      chk("t5_level", 64'(o_level), 64'(7));
      chk("t5_ready", 64'(s_ready), 64'(1));
      chk("t5_overrun", 64'(o_overrun), 64'(1));
      tick();
      chk("t5_level_after", 64'(o_level), 64'(7));

      // drain two more to reach level 5, then asynchronous reset
      i_enable = 1'b1;
      base = n_strobes;
      for (int i = 0; i < 40 && (n_strobes - base) < 2; i++) tick();
      i_enable = 1'b0;
      chk("t6_strobe_count", 64'(n_strobes - base), 64'(2));
      chk("t6_level", 64'(o_level), 64'(5));
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_strobe",   64'(o_strobe),   64'(0));
      chk("t6_rst_sample",   64'(o_sample),   64'(0));
      chk("t6_rst_level",    64'(o_level),    64'(0));
      chk("t6_rst_ready",    64'(s_ready),    64'(1));
      chk("t6_rst_underrun", 64'(o_underrun), 64'(0));
      chk("t6_rst_overrun",  64'(o_overrun),  64'(0));
      sbq.delete();
      last_exp = '0;
      tick();
      i_enable = 1'b1;
      rst_n    = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk("t6_strobe", 64'(o_strobe), 64'(k % 4 == 0));
      end
      chk("t6_underrun", 64'(o_underrun), 64'(1));

      // zero increment never strobes; new increment applies on next add
      i_phase_inc = '0;
      base = n_strobes;
      for (int i = 0; i < 20; i++) tick();
      chk("t7_zero_inc", 64'(n_strobes - base), 64'(0));
      i_phase_inc = AW'(128);
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk("t7_strobe", 64'(o_strobe), 64'(k % 2 == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
